// File: rtl/spi_aes_slave.sv
// spi_aes_slave
//   Serial front-end for an AES core. A chip-select-framed 1-bit link loads a
//   128-bit block and an NK*32-bit key (both LSB first). The slave then starts
//   the core and waits for it to finish. A later readout frame shifts the
//   captured result back out, LSB first.
//
// Ports
//   clk, rst_n     system/bit clock, asynchronous active-low reset
//   SIMO, CSS      serial data in, active-low chip select (frames a transaction)
//   mode           0 = load frame (msg+key), 1 = readout frame (result)
//   SOMI           registered serial data out
//   aes_msg        block register presented to the core
//   aes_key        key register presented to the core
//   aes_nr         round count for the core (constant, from NR)
//   aes_start      one-cycle start pulse to the core
//   aes_done       core completion strobe; aes_result valid in the same cycle
//   aes_result     core output
//   busy           high from the last load bit until aes_done
//   result_valid   result register holds a result that can be read out
//   frame_err      sticky error for the current or last frame
//   state_dbg      current FSM state encoding
//
// Core handshake: aes_start is high for exactly the one cycle spent in START.
// The core samples it on the edge that leaves START. The core answers with a
// single-cycle aes_done at any later cycle, which is always seen in WAIT.
// There is no backpressure in either direction.
module spi_aes_slave #(
  parameter int NK    = 4,
  parameter int NR    = 10,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SIMO,
  input  logic             CSS,
  input  logic             mode,
  output logic             SOMI,
  output logic [BLK_W-1:0] aes_msg,
  output logic [NK*32-1:0] aes_key,
  output logic [3:0]       aes_nr,
  output logic             aes_start,
  input  logic             aes_done,
  input  logic [BLK_W-1:0] aes_result,
  output logic             busy,
  output logic             result_valid,
  output logic             frame_err,
  output logic [2:0]       state_dbg
);

  localparam int KEY_W     = NK * 32;
  localparam int LOAD_BITS = BLK_W + KEY_W;
  localparam int CNT_W     = $clog2(LOAD_BITS + 1);
  localparam int IDX_W     = $clog2(BLK_W);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOAD_BITS);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(BLK_W - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(LOAD_BITS - 1);
  localparam logic [CNT_W-1:0] TX_END   = CNT_W'(BLK_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX_MSG = 3'd1,
    RX_KEY = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    TX     = 3'd5
  } state_t;

  state_t             state, state_n;
  logic               in_frame;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BLK_W-1:0]   result_reg;
  logic               frame_start;
  logic               shift_msg, shift_key, cnt_inc, err_set, rv_clr, capture;
  logic               somi_n;

  // CSS low now, but it was high on the previous edge (or we are just out of reset).
  assign frame_start = !CSS && !in_frame;

  assign aes_nr    = 4'(NR);
  assign aes_start = (state == START);
  assign busy      = (state == START) || (state == WAIT);
  assign state_dbg = state;

  // The frame type latched at frame start is carried by the state itself:
  // RX_* means a load frame and TX means a readout frame. START/WAIT
  // absorb any frame that begins while the core is busy.
  always_comb begin
    state_n   = state;
    shift_msg = 1'b0;
    shift_key = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    rv_clr    = 1'b0;
    capture   = 1'b0;
    somi_n    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          cnt_inc = 1'b1;              // the start edge carries bit 0
          if (!mode) begin
            shift_msg = 1'b1;
            state_n   = RX_MSG;
          end else begin
            state_n = TX;
            if (result_valid) somi_n  = result_reg[0];
            else              err_set = 1'b1;
          end
        end
      end
      RX_MSG: begin
        if (CSS) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          shift_msg = 1'b1;
          cnt_inc   = 1'b1;
          if (bit_cnt == MSG_LAST) state_n = RX_KEY;
        end
      end
      RX_KEY: begin
        if (CSS) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          shift_key = 1'b1;
          cnt_inc   = 1'b1;
          if (bit_cnt == KEY_LAST) begin
            rv_clr  = 1'b1;
            state_n = START;
          end
        end
      end
      START: begin
        if (frame_start) err_set = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (frame_start) err_set = 1'b1;
        if (aes_done) begin
          capture = 1'b1;
          state_n = IDLE;
        end
      end
      TX: begin
        if (CSS) begin
          if (bit_cnt < TX_END) err_set = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (result_valid && (bit_cnt < TX_END))
            somi_n = result_reg[bit_cnt[IDX_W-1:0]];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_frame     <= 1'b0;
      bit_cnt      <= '0;
      aes_msg      <= '0;
      aes_key      <= '0;
      result_reg   <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      SOMI         <= 1'b0;
    end else begin
      state    <= state_n;
      in_frame <= !CSS;
      SOMI     <= somi_n;

      // Counter restarts every frame and saturates rather than wrapping.
      if (frame_start)
        bit_cnt <= cnt_inc ? CNT_W'(1) : '0;
      else if (cnt_inc && (bit_cnt != CNT_MAX))
        bit_cnt <= bit_cnt + 1'b1;

      if (shift_msg) aes_msg <= {SIMO, aes_msg[BLK_W-1:1]};
      if (shift_key) aes_key <= {SIMO, aes_key[KEY_W-1:1]};

      if (capture) begin
        result_reg   <= aes_result;
        result_valid <= 1'b1;
      end else if (rv_clr) begin
        result_valid <= 1'b0;
      end

      // An error seen on the start edge itself wins over the clear.
      if (err_set)          frame_err <= 1'b1;
      else if (frame_start) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_aes_slave.sv
module tb_spi_aes_slave;

  localparam logic [127:0] FIPS_MSG = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic simo = 1'b0, mode = 1'b0, css4 = 1'b1, css8 = 1'b1;

  logic         somi4, start4, done4, busy4, rv4, err4;
  logic [127:0] msg4, res4;
  logic [127:0] key4;
  logic [3:0]   nr4;
  logic [2:0]   st4;

  logic         somi8, start8, done8, busy8, rv8, err8;
  logic [127:0] msg8, res8;
  logic [255:0] key8;
  logic [3:0]   nr8;
  logic [2:0]   st8;

  spi_aes_slave #(.NK(4), .NR(10), .BLK_W(128)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .SIMO(simo), .CSS(css4), .mode(mode),
    .SOMI(somi4), .aes_msg(msg4), .aes_key(key4), .aes_nr(nr4),
    .aes_start(start4), .aes_done(done4), .aes_result(res4),
    .busy(busy4), .result_valid(rv4), .frame_err(err4), .state_dbg(st4)
  );

  spi_aes_slave #(.NK(8), .NR(14), .BLK_W(128)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .SIMO(simo), .CSS(css8), .mode(mode),
    .SOMI(somi8), .aes_msg(msg8), .aes_key(key8), .aes_nr(nr8),
    .aes_start(start8), .aes_done(done8), .aes_result(res8),
    .busy(busy8), .result_valid(rv8), .frame_err(err8), .state_dbg(st8)
  );

  // ---------------- core models ----------------
  // Known FIPS-197 vectors return their ciphertext; anything else gets a
  // simple keyed mix so the result still depends on the loaded data.
  function automatic logic [127:0] core_fn(input logic [127:0] m, input logic [255:0] k);
    if (m == FIPS_MSG && k == {128'b0, KEY128}) return CT128;
    if (m == FIPS_MSG && k == KEY256)           return CT256;
    return m ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_0ff0_3cc3_a55a_1234_5678_9abc_def0;
  endfunction

  int lat4 = 5, lat8 = 3;
  int cnt4, cnt8;
  logic [127:0] cm4, cm8;
  logic [255:0] ck4, ck8;
  int sc4 = 0, sc8 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done4 <= 1'b0; cnt4 <= 0; res4 <= '0; cm4 <= '0; ck4 <= '0;
    end else begin
      done4 <= 1'b0;
      if (start4) begin
        cnt4 <= lat4; cm4 <= msg4; ck4 <= {128'b0, key4};
      end else if (cnt4 != 0) begin
        cnt4 <= cnt4 - 1;
        if (cnt4 == 1) begin done4 <= 1'b1; res4 <= core_fn(cm4, ck4); end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done8 <= 1'b0; cnt8 <= 0; res8 <= '0; cm8 <= '0; ck8 <= '0;
    end else begin
      done8 <= 1'b0;
      if (start8) begin
        cnt8 <= lat8; cm8 <= msg8; ck8 <= key8;
      end else if (cnt8 != 0) begin
        cnt8 <= cnt8 - 1;
        if (cnt8 == 1) begin done8 <= 1'b1; res8 <= core_fn(cm8, ck8); end
      end
    end
  end

  always @(posedge clk) begin
    if (start4) sc4++;
    if (start8) sc8++;
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_css(input int sel, input logic v);
    if (sel == 4) css4 = v; else css8 = v;
  endtask

  // Shifts n bits of stream (LSB first) with CSS low; optionally ends the frame.
  task automatic send_load(input int sel, input logic [383:0] stream, input int n, input bit release_css);
    @(negedge clk);
    mode = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_css(sel, 1'b0);
      simo = stream[i];
      @(negedge clk);
    end
    simo = 1'b0;
    if (release_css) set_css(sel, 1'b1);
  endtask

  // Bit k is sampled just after the (k+1)th edge of the frame.
  task automatic read_bits(input int sel, input int n, input bit release_css, output logic [255:0] d);
    d = '0;
    @(negedge clk);
    mode = 1'b1;
    set_css(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      d[i] = (sel == 4) ? somi4 : somi8;
    end
    if (release_css) begin
      @(negedge clk);
      set_css(sel, 1'b1);
      mode = 1'b0;
    end
  endtask

  task automatic wait_valid(input int sel, input int budget, input string tag);
    int n;
    n = 0;
    while (((sel == 4) ? rv4 : rv8) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {255'b0, ((sel == 4) ? rv4 : rv8)}, 256'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [383:0] stream;
    logic [255:0] d;
    logic [127:0] m, k, e;
    int sc_before;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctl4", {248'b0, somi4, busy4, start4, rv4, err4, st4}, 256'd0);
    check("rst_ctl8", {248'b0, somi8, busy8, start8, rv8, err8, st8}, 256'd0);
    check("rst_msg_key4", {msg4, key4}, 256'd0);
    check("nr_passthru", {248'b0, nr4, nr8}, {248'b0, 4'd10, 4'd14});
    rst_n = 1'b1;
    @(negedge clk);

    // 1) NK=4 FIPS load; 6) two readouts with 8 trailing zero bits each
    exp_q.push_back(CT128);
    exp_q.push_back(CT128);
    stream = {128'b0, KEY128, FIPS_MSG};
    send_load(4, stream, 256, 1'b1);
    check("t1_start_busy", {253'b0, start4, busy4, rv4}, {253'b0, 3'b110});
    check("t1_msg_key", {msg4, key4}, {FIPS_MSG, KEY128});
    wait_valid(4, 50, "t1_valid_timeout");
    check("t1_idle", {252'b0, busy4, st4}, 256'd0);
    for (int r = 0; r < 2; r++) begin
      read_bits(4, 136, 1'b1, d);
      e = exp_q.pop_front();
      check("t1_result", {128'b0, d[127:0]}, {128'b0, e});
      check("t6_tail_zero", {248'b0, d[135:128]}, 256'd0);
      check("t1_frame_err", {255'b0, err4}, 256'd0);
    end
    check("t6_somi_idle", {255'b0, somi4}, 256'd0);

    // 2) NK=8 FIPS load, 384 bits, single-cycle start
    exp_q.push_back(CT256);
    stream = {KEY256, FIPS_MSG};
    send_load(8, stream, 384, 1'b1);
    check("t2_start_hi", {255'b0, start8}, 256'd1);
    @(negedge clk);
    check("t2_start_1cyc", {254'b0, start8, busy8}, 256'd1);
    check("t2_start_cnt", 256'(sc8), 256'd1);
    wait_valid(8, 50, "t2_valid_timeout");
    read_bits(8, 128, 1'b1, d);
    e = exp_q.pop_front();
    check("t2_result", {128'b0, d[127:0]}, {128'b0, e});
    check("t2_frame_err", {255'b0, err8}, 256'd0);

    // 3) abort after 100 load bits, then a full random load
    sc_before = sc4;
    m = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    stream = {128'b0, k, m};
    send_load(4, stream, 100, 1'b1);
    @(negedge clk);
    check("t3_abort", {252'b0, err4, busy4, st4}, {252'b0, 1'b1, 1'b0, 3'd0});
    check("t3_no_start", 256'(sc4), 256'(sc_before));
    exp_q.push_back(core_fn(m, {128'b0, k}));
    send_load(4, stream, 256, 1'b1);
    check("t3_msg_key", {msg4, key4}, {m, k});
    wait_valid(4, 50, "t3_valid_timeout");
    check("t3_err_cleared", {255'b0, err4}, 256'd0);
    read_bits(4, 128, 1'b1, d);
    e = exp_q.pop_front();
    check("t3_result", {128'b0, d[127:0]}, {128'b0, e});

    // 4) slow core: readout attempted during WAIT
    lat4 = 20;
    m = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(core_fn(m, {128'b0, k}));
    stream = {128'b0, k, m};
    send_load(4, stream, 256, 1'b1);
    read_bits(4, 8, 1'b1, d);
    check("t4_somi_zero", d, 256'd0);
    check("t4_err_busy_rv", {253'b0, err4, busy4, rv4}, {253'b0, 3'b110});
    wait_valid(4, 100, "t4_valid_timeout");
    read_bits(4, 128, 1'b1, d);
    e = exp_q.pop_front();
    check("t4_result", {128'b0, d[127:0]}, {128'b0, e});

    // 5a) reset mid RX_KEY
    lat4 = 5;
    stream = {128'b0, ~k, ~m};
    send_load(4, stream, 200, 1'b0);
    check("t5_in_rx_key", {253'b0, st4}, 256'd2);
    rst_n = 1'b0;
    #1;
    check("t5a_ctl", {248'b0, somi4, busy4, start4, rv4, err4, st4}, 256'd0);
    check("t5a_msg_key", {msg4, key4}, 256'd0);
    @(negedge clk);
    css4 = 1'b1;
    rst_n = 1'b1;

    // 5b) reset mid TX
    m = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(core_fn(m, {128'b0, k}));
    stream = {128'b0, k, m};
    send_load(4, stream, 256, 1'b1);
    wait_valid(4, 50, "t5b_valid_timeout");
    read_bits(4, 50, 1'b0, d);
    e = exp_q.pop_front();
    check("t5b_partial", {206'b0, d[49:0]}, {206'b0, e[49:0]});
    check("t5_in_tx", {253'b0, st4}, 256'd5);
    rst_n = 1'b0;
    #1;
    check("t5b_ctl", {248'b0, somi4, busy4, start4, rv4, err4, st4}, 256'd0);
    @(negedge clk);
    css4 = 1'b1;
    mode = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("sb_empty", 256'(exp_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
